data_mem_controller: RTL and testbench

DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

---
 rtl/data_mem_controller.sv | 165 ++++++++++++++++
 tb/tb_data_mem_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// Data-memory controller between the MEM pipeline stage, a debug reader and a synchronous RAM.
// Byte/halfword stores are done as read-modify-write; loads return right-justified, zero-filled data.
module data_mem_controller #(
   parameter int  NB_DATA    = 32,
   parameter int  N_ELEMENTS = 128,
   localparam int NB_ADDR    = $clog2(N_ELEMENTS)
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               cpu_req_i,
   input  logic               cpu_we_i,
   input  logic [2:0]         cpu_size_i,
   input  logic [NB_DATA-1:0] cpu_addr_i,
   input  logic [NB_DATA-1:0] cpu_wdata_i,
   output logic [NB_DATA-1:0] cpu_rdata_o,
   output logic               cpu_stall_o,
   output logic               cpu_done_o,
   output logic               cpu_err_o,
   input  logic               dbg_req_i,
   input  logic [NB_ADDR-1:0] dbg_addr_i,
   output logic [NB_DATA-1:0] dbg_rdata_o,
   output logic               dbg_valid_o,
   output logic               mem_en_o,
   output logic               mem_we_o,
   output logic [NB_ADDR-1:0] mem_addr_o,
   output logic [NB_DATA-1:0] mem_wdata_o,
   input  logic [NB_DATA-1:0] mem_rdata_i
);

   typedef enum logic [3:0] {
      IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, DBG_RD, DBG_WAIT, DONE
   } state_t;

   localparam logic [NB_DATA-1:0] BYTE_MASK = NB_DATA'(8'hFF);
   localparam logic [NB_DATA-1:0] HALF_MASK = NB_DATA'(16'hFFFF);

   state_t               state;
   state_t               next_state;
   logic                 cpu_active_q;
   logic                 err_q;
   logic [1:0]           size_q;
   logic [1:0]           lane_q;
   logic [NB_ADDR-1:0]   word_q;
   logic [NB_ADDR-1:0]   dbg_addr_q;
   logic [NB_DATA-1:0]   wr_data_q;
   logic [NB_DATA-1:0]   cpu_rdata_q;
   logic [NB_DATA-1:0]   dbg_rdata_q;
   logic                 mem_en_raw;
   logic                 mem_we_raw;
   logic                 size_ok;
   logic                 req_misaligned;
   logic                 busy;
   logic [4:0]           lane_sh;
   logic [NB_DATA-1:0]   sub_mask;
   logic [NB_DATA-1:0]   load_data;
   logic [NB_DATA-1:0]   merge_data;
   logic                 unused_addr_bits;

   // Address bits above the 512-byte window are ignored, so accesses wrap.
   assign unused_addr_bits = ^cpu_addr_i[NB_DATA-1:NB_ADDR+2];

   assign size_ok = (cpu_size_i == 3'b001) || (cpu_size_i == 3'b010) || (cpu_size_i == 3'b100);
   assign req_misaligned = !size_ok
                           || (cpu_size_i[1] && cpu_addr_i[0])
                           || (cpu_size_i[2] && (cpu_addr_i[1:0] != 2'b00));

   assign lane_sh    = {lane_q, 3'b000};
   assign sub_mask   = size_q[0] ? BYTE_MASK : (size_q[1] ? HALF_MASK : '1);
   assign load_data  = (mem_rdata_i >> lane_sh) & sub_mask;
   assign merge_data = (mem_rdata_i & ~(sub_mask << lane_sh)) | ((wr_data_q & sub_mask) << lane_sh);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_en_raw = 1'b0;
      mem_we_raw = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req_i) begin
               if (req_misaligned)    next_state = DONE;
               else if (!cpu_we_i)    next_state = RD;
               else if (cpu_size_i[2]) next_state = WR;
               else                   next_state = RMW_RD;
            end else if (dbg_req_i) begin
               next_state = DBG_RD;
            end
         end
         RD: begin
            mem_en_raw = 1'b1;
            next_state = RD_WAIT;
         end
         RD_WAIT:  next_state = DONE;
         RMW_RD: begin
            mem_en_raw = 1'b1;
            next_state = RMW_WAIT;
         end
         RMW_WAIT: next_state = WR;
         WR: begin
            mem_en_raw = 1'b1;
            mem_we_raw = 1'b1;
            next_state = DONE;
         end
         DBG_RD: begin
            mem_en_raw = 1'b1;
            next_state = DBG_WAIT;
         end
         DBG_WAIT: next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cpu_active_q <= 1'b0;
         err_q        <= 1'b0;
         size_q       <= '0;
         lane_q       <= '0;
         word_q       <= '0;
         dbg_addr_q   <= '0;
         wr_data_q    <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         if (state == IDLE) begin
            if (cpu_req_i) begin
               cpu_active_q <= 1'b1;
               err_q        <= req_misaligned;
               size_q       <= cpu_size_i[1:0];
               lane_q       <= cpu_addr_i[1:0];
               word_q       <= cpu_addr_i[NB_ADDR+1:2];
               wr_data_q    <= cpu_wdata_i;
            end else if (dbg_req_i) begin
               cpu_active_q <= 1'b0;
               err_q        <= 1'b0;
               dbg_addr_q   <= dbg_addr_i;
            end
         end
         if (state == RD_WAIT)  cpu_rdata_q <= load_data;
         if (state == RMW_WAIT) wr_data_q   <= merge_data;
         if (state == DBG_WAIT) dbg_rdata_q <= mem_rdata_i;
      end
   end

   // Every output is forced low while reset is held, so an aborted store cannot write.
   assign busy        = (state != IDLE) && (state != DONE);
   assign cpu_stall_o = !reset_i && ((cpu_req_i && (state == IDLE)) || (busy && cpu_active_q));
   assign cpu_done_o  = !reset_i && (state == DONE) && cpu_active_q;
   assign cpu_err_o   = !reset_i && (state == DONE) && cpu_active_q && err_q;
   assign dbg_valid_o = !reset_i && (state == DONE) && !cpu_active_q;
   assign cpu_rdata_o = reset_i ? '0 : cpu_rdata_q;
   assign dbg_rdata_o = reset_i ? '0 : dbg_rdata_q;
   assign mem_en_o    = !reset_i && mem_en_raw;
   assign mem_we_o    = !reset_i && mem_we_raw;
   assign mem_addr_o  = reset_i ? '0 : (cpu_active_q ? word_q : dbg_addr_q);
   assign mem_wdata_o = reset_i ? '0 : wr_data_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: byte-array reference memory, directed scenarios and random
// loads/stores/debug reads, with a synchronous RAM model attached to the memory port.
module tb_data_mem_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [2:0]  cpu_size;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_done;
   logic        cpu_err;
   logic        dbg_req;
   logic [6:0]  dbg_addr;
   logic [31:0] dbg_rdata;
   logic        dbg_valid;
   logic        mem_en;
   logic        mem_we;
   logic [6:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] ram [128];
   bit   [7:0]  ref_mem [512];
   logic [31:0] exp_q [$];
   logic [31:0] last_rdata;
   logic [31:0] last_dbg;
   logic [2:0]  bad_sizes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
   int          checks = 0;
   int          failures = 0;
   int          en_cnt = 0;
   int          we_cnt = 0;
   int          cyc = 0;

   data_mem_controller dut (
      .clock_i     (clk),
      .reset_i     (reset),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_size_i  (cpu_size),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .cpu_stall_o (cpu_stall),
      .cpu_done_o  (cpu_done),
      .cpu_err_o   (cpu_err),
      .dbg_req_i   (dbg_req),
      .dbg_addr_i  (dbg_addr),
      .dbg_rdata_o (dbg_rdata),
      .dbg_valid_o (dbg_valid),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous RAM behind the controller
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: plain byte-addressed memory, little-endian
   function automatic bit is_misaligned(input logic [2:0] size, input logic [31:0] addr);
      case (size)
         3'b001:  return 1'b0;
         3'b010:  return addr[0];
         3'b100:  return addr[1:0] != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int nbytes(input logic [2:0] size);
      return (size == 3'b001) ? 1 : (size == 3'b010) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr);
      logic [31:0] v = 0;
      int base = int'(addr % 512);
      for (int i = 0; i < nbytes(size); i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
      return v;
   endfunction

   function automatic void ref_store(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
      int base = int'(addr % 512);
      for (int i = 0; i < nbytes(size); i++) ref_mem[base + i] = 8'(d >> (8 * i));
   endfunction

   function automatic logic [31:0] ref_word(input int idx);
      return ref_load(3'b100, 32'(idx * 4));
   endfunction

   task automatic outputs_zero(input string tag);
      check({tag, "_cpu_rdata"}, cpu_rdata, 0);
      check({tag, "_dbg_rdata"}, dbg_rdata, 0);
      check({tag, "_ctrl"}, {26'b0, cpu_stall, cpu_done, cpu_err, dbg_valid, mem_en, mem_we}, 0);
      check({tag, "_mem_addr"}, {25'b0, mem_addr}, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   // driver: one CPU access, checked for latency, stall, err, data and memory traffic
   task automatic cpu_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag);
      int n, en0, we0, stall_bad, exp_lat, exp_en, exp_we;
      bit got, exp_err;
      logic [31:0] exp_rd;
      exp_err = is_misaligned(size, addr);
      exp_lat = exp_err ? 1 : (!we ? 3 : (size == 3'b100 ? 2 : 4));
      exp_en  = exp_err ? 0 : (we && size != 3'b100) ? 2 : 1;
      exp_we  = (!exp_err && we) ? 1 : 0;
      if (!exp_err && !we) exp_q.push_back(ref_load(size, addr));
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
      en0 = en_cnt; we0 = we_cnt; n = 0; got = 1'b0; stall_bad = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (cpu_done) got = 1'b1;
         else begin
            if (!cpu_stall) stall_bad++;
            @(posedge clk);
            n++;
         end
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_stall_before_done"}, stall_bad, 0);
      check({tag, "_stall_in_done"}, {31'b0, cpu_stall}, 0);
      check({tag, "_err"}, {31'b0, cpu_err}, {31'b0, exp_err});
      check({tag, "_dbg_rdata_hold"}, dbg_rdata, last_dbg);
      if (!exp_err && !we) begin
         exp_rd = exp_q.pop_front();
         last_rdata = exp_rd;
      end
      check({tag, "_rdata"}, cpu_rdata, last_rdata);
      if (!exp_err && we) ref_store(size, addr, wdata);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      check({tag, "_mem_en_cycles"}, en_cnt - en0, exp_en);
      check({tag, "_mem_we_cycles"}, we_cnt - we0, exp_we);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {30'b0, cpu_done, cpu_err}, 0);
   endtask

   task automatic dbg_read(input int idx, input string tag);
      int n;
      bit got;
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_addr = 7'(idx);
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (dbg_valid) got = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      check({tag, "_latency"}, n, 3);
      check({tag, "_data"}, dbg_rdata, ref_word(idx));
      check({tag, "_cpu_done_low"}, {31'b0, cpu_done}, 0);
      last_dbg = ref_word(idx);
      @(posedge clk); #1;
      dbg_req = 1'b0;
   endtask

   initial begin
      int n, d_cyc, we0;
      bit got;
      logic [31:0] exp_cpu, exp_dbg;
      for (int i = 0; i < 128; i++) ram[i] = 32'h0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h0;
      mem_rdata = 32'h0;
      last_rdata = 32'h0; last_dbg = 32'h0;
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 3'b100;
      cpu_addr = 32'h0; cpu_wdata = 32'h0; dbg_req = 1'b0; dbg_addr = 7'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outputs_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // word store then word load
      cpu_access(1'b1, 3'b100, 32'h10, 32'hDEADBEEF, "sw_10");
      cpu_access(1'b0, 3'b100, 32'h10, 32'h0, "lw_10");
      check("lw_10_value", cpu_rdata, 32'hDEADBEEF);

      // byte merge into a word
      cpu_access(1'b1, 3'b100, 32'h20, 32'h11223344, "sw_20");
      cpu_access(1'b1, 3'b001, 32'h21, 32'hFFFFFFAA, "sb_21");
      cpu_access(1'b0, 3'b100, 32'h20, 32'h0, "lw_20");
      check("lw_20_value", cpu_rdata, 32'h1122AA44);
      cpu_access(1'b0, 3'b001, 32'h23, 32'h0, "lb_23");
      check("lb_23_value", cpu_rdata, 32'h00000011);

      // halfword merge into the upper lane
      cpu_access(1'b1, 3'b100, 32'h20, 32'h11223344, "sw_20b");
      cpu_access(1'b1, 3'b010, 32'h22, 32'h1234BEEF, "sh_22");
      cpu_access(1'b0, 3'b100, 32'h20, 32'h0, "lw_20b");
      check("lw_20b_value", cpu_rdata, 32'hBEEF3344);
      cpu_access(1'b0, 3'b010, 32'h22, 32'h0, "lh_22");
      check("lh_22_value", cpu_rdata, 32'h0000BEEF);

      // misaligned accesses and a wrapped address
      cpu_access(1'b0, 3'b010, 32'h21, 32'h0, "lh_21_misaligned");
      cpu_access(1'b1, 3'b100, 32'h22, 32'h55555555, "sw_22_misaligned");
      cpu_access(1'b0, 3'b011, 32'h20, 32'h0, "bad_size");
      cpu_access(1'b0, 3'b100, 32'hFFFF_FE10, 32'h0, "lw_wrap");
      check("lw_wrap_value", cpu_rdata, 32'hDEADBEEF);

      // simultaneous CPU and debug requests
      @(posedge clk); #1;
      exp_cpu = ref_load(3'b100, 32'h10);
      exp_dbg = ref_word(8);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 3'b100; cpu_addr = 32'h10;
      dbg_req = 1'b1; dbg_addr = 7'd8;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (cpu_done) got = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      d_cyc = cyc;
      check("both_cpu_latency", n, 3);
      check("both_cpu_rdata", cpu_rdata, exp_cpu);
      check("both_dbg_not_first", {31'b0, dbg_valid}, 0);
      last_rdata = exp_cpu;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (dbg_valid) got = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      check("both_dbg_gap", cyc - d_cyc, 4);
      check("both_dbg_data", dbg_rdata, exp_dbg);
      last_dbg = exp_dbg;
      @(posedge clk); #1;
      dbg_req = 1'b0;

      // reset in the merge cycle of a byte store aborts it
      @(posedge clk); #1;
      we0 = we_cnt;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 3'b001; cpu_addr = 32'h21; cpu_wdata = 32'h77;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      outputs_zero("rst_mid");
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(negedge clk);
      outputs_zero("rst_held");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_no_write", we_cnt - we0, 0);
      check("rst_cpu_rdata_cleared", cpu_rdata, 0);
      last_rdata = 32'h0; last_dbg = 32'h0;
      dbg_read(8, "rst_word_intact");
      check("rst_word_value", dbg_rdata, 32'hBEEF3344);

      // random traffic
      for (int i = 0; i < 200; i++) begin
         int sel;
         logic [2:0] sz;
         logic [31:0] a;
         sel = $urandom_range(0, 9);
         sz = (sel < 3) ? 3'b001 : (sel < 6) ? 3'b010 : (sel < 9) ? 3'b100 : bad_sizes[$urandom_range(0, 4)];
         a = $urandom();
         if ($urandom_range(0, 1) == 1) a[8:0] = 9'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 3'b010) a[0] = 1'b0;
            if (sz == 3'b100) a[1:0] = 2'b00;
         end
         cpu_access(1'($urandom_range(0, 1)), sz, a, $urandom(), "rnd");
         if (i % 20 == 19) dbg_read($urandom_range(0, 127), "rnd_dbg");
      end

      for (int w = 0; w < 128; w++) dbg_read(w, "sweep");
      check("exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
